// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: default widths, ALU opcodes,
// requester ids and the response-slot state encoding.
package alu_share_arbiter_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_OPW   = 3;
    localparam int unsigned DEF_CNTW  = 16;

    localparam logic [DEF_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OPW-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'b011;
    localparam logic [DEF_OPW-1:0] OP_SLT = 3'b100;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: grants one valid requester when the response
// slot can take a result, and advances the pointer past the winner.
module alu_rr_pick
    import alu_share_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    input  logic       slot_free,
    output logic [1:0] grant,
    output logic       ptr_next
);

    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (slot_free) begin
            if (valid0 && valid1) begin
                grant = (ptr == ID_REQ0) ? 2'b01 : 2'b10;
            end else if (valid0) begin
                grant = 2'b01;
            end else if (valid1) begin
                grant = 2'b10;
            end
        end
        // Winner goes to the back of the line
        if (grant[0]) begin
            ptr_next = ID_REQ1;
        end else if (grant[1]) begin
            ptr_next = ID_REQ0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One shared ALU between the EX stage (req0) and the branch/address helper
// (req1): round-robin grant, single registered response slot tagged by id.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNTW-1:0]  contention
);

    rsp_state_t       state_q;
    rsp_state_t       state_next;
    logic             ptr_q;
    logic             ptr_next;
    logic [1:0]       grant;
    logic             slot_free;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   op_code;
    logic [WIDTH-1:0] alu_res;

    assign rsp_valid = (state_q == ST_FULL);

    // Gated by rst_n so no handshake completes while reset is held
    assign slot_free = rst_n && (!rsp_valid || rsp_ready);

    alu_rr_pick u_pick (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .ptr       (ptr_q),
        .slot_free (slot_free),
        .grant     (grant),
        .ptr_next  (ptr_next)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel        = grant[1];

    assign op_a    = sel ? req1_a  : req0_a;
    assign op_b    = sel ? req1_b  : req0_b;
    assign op_code = sel ? req1_op : req0_op;

    // Shared ALU; unknown opcodes yield zero
    always_comb begin
        alu_res = '0;
        case (op_code)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= ID_REQ0;
            rsp_id     <= ID_REQ0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            contention <= '0;
        end else begin
            state_q <= state_next;
            ptr_q   <= ptr_next;
            if (accept) begin
                rsp_id     <= sel;
                rsp_result <= alu_res;
                rsp_zero   <= (alu_res == '0);
            end
            if (req0_valid && req1_valid && (contention != {CNTW{1'b1}})) begin
                contention <= contention + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the driver pushes hand-computed
// responses, a negedge monitor pops them on every response handshake.
module tb_alu_share_arbiter;

    localparam int unsigned W    = 32;
    localparam int unsigned OW   = 3;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [W-1:0]  rsp_result;
    logic [CW-1:0] contention;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu_share_arbiter #(.WIDTH(W), .OPW(OW), .CNTW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .contention (contention)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check readys mid-cycle, push expected result on grant
    task automatic issue(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [OW-1:0] op0, input logic v1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic [OW-1:0] op1, input logic rr,
                         input logic [1:0] exp_rdy, input logic [W-1:0] exp_res);
        exp_t e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rr;
        #2;
        chk("readys", W'({req1_ready, req0_ready}), W'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            e.id   = exp_rdy[1];
            e.res  = exp_res;
            e.zero = (exp_res == '0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        issue(1'b0, '0, '0, 3'b000, 1'b0, '0, '0, 3'b000, rr, 2'b00, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got id=%0d result=0x%0h expected none", rsp_id, rsp_result);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", W'(rsp_id), W'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_zero", W'(rsp_zero), W'(e.zero));
            end
        end
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = '0;
        #2;
        chk("rst_readys_early", W'({req1_ready, req0_ready}), '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readys", W'({req1_ready, req0_ready}), '0);
        chk("rst_valid", W'(rsp_valid), '0);
        chk("rst_contention", W'(contention), '0);
        chk("rst_result", rsp_result, '0);
        chk("rst_id_zero", W'({rsp_id, rsp_zero}), '0);
        rst_n = 1'b1;

        // Single op, then a lone req1 op so the pointer favours req0 again
        issue(1'b1, 32'd7, 32'd5, 3'b000, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'd12);
        chk("single_valid", W'(rsp_valid), 32'd1);
        issue(1'b0, '0, '0, 3'b000, 1'b1, 32'd1, 32'd2, 3'b000, 1'b1, 2'b10, 32'd3);

        // Contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'd9, 32'd9, 3'b001, 1'b1, 32'hF0, 32'h0F, 3'b011, 1'b1,
                  (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 32'd0 : 32'hFF);
        end
        chk("contention_4", W'(contention), 32'd4);

        // Backpressure: hold result, no grants, then drain+reload together
        issue(1'b1, 32'd100, 32'd1, 3'b001, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'd99);
        chk("bp_valid", W'(rsp_valid), 32'd1);
        chk("bp_result", rsp_result, 32'd99);
        issue(1'b1, 32'd5, 32'd5, 3'b000, 1'b1, 32'h10, 32'h20, 3'b000, 1'b0, 2'b00, '0);
        chk("bp_hold", rsp_result, 32'd99);
        issue(1'b1, 32'd5, 32'd5, 3'b000, 1'b1, 32'h10, 32'h20, 3'b000, 1'b0, 2'b00, '0);
        chk("bp_hold2", rsp_result, 32'd99);
        issue(1'b1, 32'd5, 32'd5, 3'b000, 1'b1, 32'h10, 32'h20, 3'b000, 1'b1, 2'b10, 32'h30);
        chk("reload_valid", W'(rsp_valid), 32'd1);

        // Op coverage and add wrap
        issue(1'b1, 32'hC, 32'hA, 3'b010, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'h8);
        issue(1'b0, '0, '0, 3'b000, 1'b1, 32'd3, 32'd8, 3'b100, 1'b1, 2'b10, 32'd1);
        issue(1'b1, 32'd8, 32'd3, 3'b100, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'd0);
        issue(1'b0, '0, '0, 3'b000, 1'b1, 32'd5, 32'd6, 3'b111, 1'b1, 2'b10, 32'd0);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'd0);
        idle(1'b1);
        chk("contention_7", W'(contention), 32'd7);

        // Fill the slot, then saturate the counter while stalled
        issue(1'b1, 32'd2, 32'd2, 3'b000, 1'b0, '0, '0, 3'b000, 1'b1, 2'b01, 32'd4);
        for (int i = 0; i < 12; i++) begin
            issue(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 2'b00, '0);
            if (i == 7) chk("contention_sat", W'(contention), 32'd15);
        end
        chk("contention_hold", W'(contention), 32'd15);
        chk("full_before_rst", W'(rsp_valid), 32'd1);

        // Mid-operation reset drops the held response and resets the pointer
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        #2;
        chk("midrst_readys", W'({req1_ready, req0_ready}), '0);
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_valid", W'(rsp_valid), '0);
        chk("midrst_contention", W'(contention), '0);
        rst_n = 1'b1;
        issue(1'b1, 32'd7, 32'd5, 3'b000, 1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 2'b01, 32'd12);
        idle(1'b1);
        idle(1'b1);
        chk("sb_empty", W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
